// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and constants for seven-segment display blocks
//
// Contents:
//   seg_state_t : scanner state encoding (IDLE, DRIVE, BLANK)
//   SEG_OFF     : all segments dark, active-low
//   HEX_SEG     : hex nibble to active-low segment code, a..g on [7:1], dp on [0] (off)
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } seg_state_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam logic [7:0] HEX_SEG [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1B,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

endpackage

// File: rtl/seg_hex_encode.sv
// rtl/seg_hex_encode.sv - combinational hex nibble plus decimal point to segment code
//
// Ports:
//   i_nibble : hex digit value
//   i_dp     : 1 = light the decimal point
//   o_code   : active-low segments, a..g on [7:1], dp on [0]
module seg_hex_encode
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  output logic [7:0] o_code
);

  // Every table entry has bit0 set (dp off), so the dp request only ever clears it.
  assign o_code = HEX_SEG[i_nibble] & {7'h7F, ~i_dp};

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - multiplexed hex display scanner with per-frame snapshot
//
// Scans NUM_DIGITS hex digits onto a shared active-low segment bus. Each digit is
// driven for DIV clocks, followed by BLANK_CYCLES dark clocks. Inputs are captured
// once per frame so a frame never mixes old and new data.
// Optional build macro: LEADING_ZERO_BLANK_EN (treat leading zero digits as masked).
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : 1 = scanning, 0 = dark and parked in IDLE
//   in_data      : nibble i drives digit i
//   dp_in        : decimal point request per digit
//   digit_mask   : 1 = digit may light
//   display_data : active-low segments a..g on [7:1], dp on [0]
//   display_en   : active-low digit anodes, at most one low
//   frame_done   : one-clock pulse on the first drive of digit 0 after a wrap
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIV          = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [4*NUM_DIGITS-1:0]   in_data,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     digit_mask,
  output logic [7:0]                display_data,
  output logic [NUM_DIGITS-1:0]     display_en,
  output logic                      frame_done
);

  localparam int CNT_RANGE = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
  localparam int CNT_W     = $clog2((CNT_RANGE < 2) ? 2 : CNT_RANGE);
  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  seg_state_t                r_state;
  logic [IDX_W-1:0]          r_idx;
  logic [CNT_W-1:0]          r_cnt;
  logic [4*NUM_DIGITS-1:0]   r_snap_data;
  logic [NUM_DIGITS-1:0]     r_snap_dp;
  logic [NUM_DIGITS-1:0]     r_snap_mask;

  logic                      w_drive_end;
  logic                      w_blank_end;
  logic                      w_slot_end;
  logic                      w_wrap;
  logic                      w_load;
  logic [IDX_W-1:0]          w_next_idx;
  logic [NUM_DIGITS-1:0]     w_in_mask;
  logic [4*NUM_DIGITS-1:0]   w_src_data;
  logic [NUM_DIGITS-1:0]     w_src_dp;
  logic [NUM_DIGITS-1:0]     w_src_mask;
  logic [3:0]                w_nibble;
  logic                      w_dp;
  logic [NUM_DIGITS-1:0]     w_en_drive;
  logic [7:0]                w_code;

  assign w_drive_end = (r_state == DRIVE) && (r_cnt == DIV_LAST);
  assign w_blank_end = (r_state == BLANK) && (r_cnt == BLANK_LAST);
  assign w_slot_end  = HAS_BLANK ? w_blank_end : w_drive_end;
  assign w_wrap      = w_slot_end && (r_idx == IDX_LAST);
  assign w_load      = enable && ((r_state == IDLE) || w_wrap);

  // Index of the digit driven after this edge; only moves at slot end.
  assign w_next_idx  = w_load     ? '0 :
                       w_slot_end ? r_idx + IDX_W'(1) : r_idx;

  // On a snapshot edge the outgoing digit must come from the live inputs,
  // because the snapshot registers only update on that same edge.
  assign w_src_data  = w_load ? in_data   : r_snap_data;
  assign w_src_dp    = w_load ? dp_in     : r_snap_dp;
  assign w_src_mask  = w_load ? w_in_mask : r_snap_mask;

`ifdef LEADING_ZERO_BLANK_EN
  logic w_lzb_run;

  // Walk down from the top digit; the run stops at the first non-zero
  // nibble or the first digit asking for its decimal point. Digit 0 always shows.
  always_comb begin
    w_in_mask = digit_mask;
    w_lzb_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (w_lzb_run && (in_data[4*i +: 4] == 4'h0) && !dp_in[i]) begin
        w_in_mask[i] = 1'b0;
      end else begin
        w_lzb_run = 1'b0;
      end
    end
  end
`else
  always_comb begin
    w_in_mask = digit_mask;
  end
`endif

  always_comb begin
    w_nibble   = 4'h0;
    w_dp       = 1'b0;
    w_en_drive = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_next_idx == IDX_W'(i)) begin
        w_nibble      = w_src_data[4*i +: 4];
        w_dp          = w_src_dp[i];
        w_en_drive[i] = ~w_src_mask[i];
      end
    end
  end

  seg_hex_encode u_encode (
    .i_nibble (w_nibble),
    .i_dp     (w_dp),
    .o_code   (w_code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_snap_data  <= '0;
      r_snap_dp    <= '0;
      r_snap_mask  <= '0;
      display_data <= SEG_OFF;
      display_en   <= '1;
      frame_done   <= 1'b0;
    end else if (!enable) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      display_data <= SEG_OFF;
      display_en   <= '1;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (w_load) begin
        r_snap_data <= in_data;
        r_snap_dp   <= dp_in;
        r_snap_mask <= w_in_mask;
      end
      case (r_state)
        IDLE: begin
          r_state      <= DRIVE;
          r_idx        <= '0;
          r_cnt        <= '0;
          display_data <= w_code;
          display_en   <= w_en_drive;
        end
        DRIVE: begin
          if (r_cnt == DIV_LAST) begin
            r_cnt <= '0;
            if (HAS_BLANK) begin
              r_state      <= BLANK;
              display_data <= SEG_OFF;
              display_en   <= '1;
            end else begin
              r_idx        <= w_next_idx;
              display_data <= w_code;
              display_en   <= w_en_drive;
              frame_done   <= w_wrap;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            r_cnt        <= '0;
            r_state      <= DRIVE;
            r_idx        <= w_next_idx;
            display_data <= w_code;
            display_en   <= w_en_drive;
            frame_done   <= w_wrap;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
